mul_operand_sequencer: RTL and testbench

- Upstream feeder for the repeated-addition multiplier (MUL_datapath + controller).
- Buffers operand pairs arriving on a valid/ready interface in a small FIFO.
- Drives the multiplier's shared data_in bus and start line with the required cycle sequence: start, A, B. Waits for done, then retires the job.
- Supervises each job with a timeout and keeps a completed-job count.

---
 rtl/mul_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/mul_operand_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mul_operand_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared types for the repeated-addition multiplier operand
//            sequencer: sequencer states, operand-pair layout, default width.
// Revision : 1.0  initial release
// ============================================================================
package mul_pkg;

  // Default operand width; matches the multiplier data_in bus.
  localparam int MUL_DATA_W = 16;

  // Job sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5,
    ABORT  = 3'd6
  } mul_state_e;

  // One queued job at the default width: multiplicand a, count operand b.
  typedef struct packed {
    logic [MUL_DATA_W-1:0] a;
    logic [MUL_DATA_W-1:0] b;
  } mul_pair_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with wrap-bit pointers and a registered head.
//            Pushes while full and pops while empty are ignored.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Full when the wrap bits differ but the index bits coincide.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/mul_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_operand_sequencer
// Purpose  : Buffers operand pairs and plays them into the repeated-addition
//            multiplier as start, A, B on a shared bus, then waits for the
//            done edge (or a timeout) before retiring the job.
// Revision : 1.0  initial release
// ============================================================================
module mul_operand_sequencer
  import mul_pkg::*;
#(
  parameter int DATA_W  = MUL_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] mul_data,
  output logic              mul_start,
  input  logic              mul_done,
  output logic              busy,
  output logic [15:0]       jobs_done,
  output logic              timeout_err
);

  localparam int PAIR_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } pair_t;

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              done_q, done_d;
  logic              mul_start_q, mul_start_d;
  logic [DATA_W-1:0] mul_data_q, mul_data_d;
  logic [15:0]       jobs_done_q, jobs_done_d;
  logic              timeout_err_q, timeout_err_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAIR_W-1:0] fifo_wr_data;
  logic [PAIR_W-1:0] fifo_rd_data;
  pair_t             wr_pair;
  pair_t             head;
  logic              done_rise;

  assign wr_pair      = '{a: in_a, b: in_b};
  assign fifo_wr_data = wr_pair;
  assign head         = pair_t'(fifo_rd_data);
  assign fifo_push    = in_valid && !fifo_full;
  assign done_rise    = mul_done && !done_q;

  sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Job sequencing; the head entry stays in the FIFO until the job retires.
  // The timeout counter holds the number of cycles since START was entered,
  // so START seeds it with one.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = START;
      end
      START: begin
        tmo_cnt_d = C_CNT_ONE;
        state_d   = LOAD_A;
      end
      LOAD_A: begin
        tmo_cnt_d = tmo_cnt_q + C_CNT_ONE;
        state_d   = LOAD_B;
      end
      LOAD_B: begin
        tmo_cnt_d = tmo_cnt_q + C_CNT_ONE;
        state_d   = WAIT;
      end
      WAIT: begin
        // A done edge wins over a timeout landing on the same cycle.
        if (done_rise) begin
          state_d = DONE;
        end else if (tmo_cnt_q >= C_TMO_LAST) begin
          state_d = ABORT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + C_CNT_ONE;
        end
      end
      DONE: begin
        fifo_pop = 1'b1;
        state_d  = IDLE;
      end
      ABORT: begin
        fifo_pop = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered values
  // line up with the state they belong to.
  always_comb begin
    done_d        = mul_done;
    mul_start_d   = (state_d == START);
    mul_data_d    = '0;
    jobs_done_d   = jobs_done_q;
    timeout_err_d = timeout_err_q;
    case (state_d)
      LOAD_A:      mul_data_d = head.a;
      LOAD_B, WAIT: mul_data_d = head.b;
      default:     mul_data_d = '0;
    endcase
    if (state_q == DONE)  jobs_done_d   = jobs_done_q + 16'd1;
    if (state_q == ABORT) timeout_err_d = 1'b1;
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      done_q        <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_data_q    <= '0;
      jobs_done_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      done_q        <= done_d;
      mul_start_q   <= mul_start_d;
      mul_data_q    <= mul_data_d;
      jobs_done_q   <= jobs_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign busy        = (state_q != IDLE);
  assign mul_start   = mul_start_q;
  assign mul_data    = mul_data_q;
  assign jobs_done   = jobs_done_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_operand_sequencer
// Purpose  : Self-checking bench for mul_operand_sequencer with a job-level
//            reference model and a multiplier emulator.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_operand_sequencer;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic              in_ready;
  logic [DATA_W-1:0] mul_data;
  logic              mul_start;
  logic              mul_done;
  logic              busy;
  logic [15:0]       jobs_done;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_operand_sequencer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_data    (mul_data),
    .mul_start   (mul_start),
    .mul_done    (mul_done),
    .busy        (busy),
    .jobs_done   (jobs_done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Multiplier emulator: raises done 2+delay cycles after start (delay cycles
  // after B is on the bus) for two cycles. When disabled, man_done is used.
  // --------------------------------------------------------------------------
  logic emu_auto = 1'b0;
  logic emu_done = 1'b0;
  logic man_done = 1'b0;
  bit   rand_delay = 1'b0;
  int   fixed_delay = 6;
  int   emu_cnt = -1;
  int   cur_delay = 0;

  assign mul_done = emu_auto ? emu_done : man_done;

  always @(negedge clk) begin
    if (rst || !emu_auto) begin
      emu_cnt  = -1;
      emu_done = 1'b0;
    end else if (mul_start) begin
      emu_cnt   = 0;
      emu_done  = 1'b0;
      cur_delay = rand_delay ? int'($urandom_range(0, 15)) : fixed_delay;
    end else if (emu_cnt >= 0) begin
      emu_cnt++;
      if (emu_cnt == 2 + cur_delay) begin
        emu_done = 1'b1;
      end else if (emu_cnt == 4 + cur_delay) begin
        emu_done = 1'b0;
        emu_cnt  = -1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model. m_t is the number of cycles since the current job was
  // launched (-1 when no job is active); m_end marks the retire cycle
  // (1 = completed, 2 = aborted). The queue holds every accepted pair,
  // including the one being worked on.
  // --------------------------------------------------------------------------
  mul_pkg::mul_pair_t mq[$];
  int          m_t = -1;
  int          m_end = 0;
  logic [15:0] m_jobs = '0;
  logic        m_err = 1'b0;
  logic        m_dprev = 1'b0;
  logic        preload = 1'b0;
  int          m_old_size;
  bit          m_rise;
  bit          m_take;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_t     = -1;
      m_end   = 0;
      m_jobs  = '0;
      m_err   = 1'b0;
      m_dprev = 1'b0;
    end else begin
      m_old_size = mq.size();
      m_rise     = mul_done && !m_dprev;
      m_take     = in_valid && (m_old_size < DEPTH);
      m_dprev    = mul_done;
      if (m_end != 0) begin
        if (m_end == 1) m_jobs = m_jobs + 16'd1;
        else            m_err  = 1'b1;
        void'(mq.pop_front());
        m_end = 0;
        m_t   = -1;
      end else if (m_t < 0) begin
        if (m_old_size > 0) m_t = 0;
      end else if (m_t < 3) begin
        m_t++;
      end else if (m_rise) begin
        m_end = 1;
      end else if (m_t == TIMEOUT - 1) begin
        m_end = 2;
      end else begin
        m_t++;
      end
      if (m_take) mq.push_back('{a: in_a, b: in_b});
      if (preload) m_jobs = 16'hFFFF;
    end
  end

  // Cycle-by-cycle comparison against the model.
  logic [DATA_W-1:0] exp_data;
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      check("busy", 32'(busy), 32'(m_t >= 0 || m_end != 0));
      check("mul_start", 32'(mul_start), 32'(m_t == 0 && m_end == 0));
      if (m_end == 0) begin
        if (m_t <= 0)      exp_data = '0;
        else if (m_t == 1) exp_data = mq[0].a;
        else               exp_data = mq[0].b;
        check("mul_data", 32'(mul_data), 32'(exp_data));
      end
      if (!preload) check("jobs_done", 32'(jobs_done), 32'(m_jobs));
      check("timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  // Records the A operand presented after each start pulse.
  logic [DATA_W-1:0] a_seen[$];
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      a_seen.delete();
      prev_start = 1'b0;
    end else begin
      if (prev_start) a_seen.push_back(mul_data);
      prev_start = mul_start;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    man_done = 1'b0;
    emu_auto = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bound_fail("push_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (mul_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_start");
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    int exp_a[5];
    bit ok;
    exp_a = '{10, 20, 30, 40, 50};

    // Reset state and single job (17, 5), done 6 cycles after B.
    do_reset();
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(mul_start), 32'd0);
    check("rst_data", 32'(mul_data), 32'd0);
    check("rst_jobs", 32'(jobs_done), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rand_delay  = 1'b0;
    fixed_delay = 6;
    emu_auto    = 1'b1;
    push_pair(16'd17, 16'd5);
    wait_start(10);
    check("single_start_data", 32'(mul_data), 32'd0);
    @(negedge clk);
    check("single_start_len", 32'(mul_start), 32'd0);
    check("single_a", 32'(mul_data), 32'd17);
    @(negedge clk);
    check("single_b", 32'(mul_data), 32'd5);
    wait_idle(40);
    @(negedge clk);
    check("single_jobs", 32'(jobs_done), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // Fill and backpressure with the multiplier stalled.
    do_reset();
    push_pair(16'd10, 16'd1);
    push_pair(16'd20, 16'd2);
    push_pair(16'd30, 16'd3);
    push_pair(16'd40, 16'd4);
    check("fill_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'd50;
    in_b     = 16'd5;
    @(negedge clk);
    check("fill_hold", 32'(in_ready), 32'd0);
    man_done = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("fill_ready_return");
    check("fill_after_done", 32'(jobs_done), 32'd1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    man_done    = 1'b0;
    fixed_delay = 3;
    emu_auto    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (jobs_done == 16'd5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("fill_drain");
    check("order_count", 32'(a_seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < a_seen.size()) check("order_a", 32'(a_seen[i]), 32'(exp_a[i]));
    end

    // Timeout with done held low, then the next pair runs normally.
    do_reset();
    push_pair(16'd3, 16'd4);
    push_pair(16'd6, 16'd7);
    wait_start(10);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 15) begin
        check("tmo_busy15", 32'(busy), 32'd1);
        check("tmo_err15", 32'(timeout_err), 32'd0);
      end
      if (k == 16) begin
        check("tmo_abort_busy", 32'(busy), 32'd1);
        check("tmo_abort_start", 32'(mul_start), 32'd0);
      end
      if (k == 17) begin
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_jobs", 32'(jobs_done), 32'd0);
        fixed_delay = 2;
        emu_auto    = 1'b1;
      end
      if (k == 18) check("tmo_next_start", 32'(mul_start), 32'd1);
    end
    wait_idle(40);
    check("tmo_next_jobs", 32'(jobs_done), 32'd1);
    check("tmo_sticky", 32'(timeout_err), 32'd1);

    // Level done: mul_done already high before the job starts.
    do_reset();
    man_done = 1'b1;
    repeat (3) @(negedge clk);
    push_pair(16'd9, 16'd9);
    wait_start(10);
    wait_idle(40);
    check("level_jobs", 32'(jobs_done), 32'd0);
    check("level_err", 32'(timeout_err), 32'd1);

    // Asynchronous reset in WAIT with the FIFO full.
    man_done = 1'b0;
    push_pair(16'd1, 16'd11);
    push_pair(16'd2, 16'd12);
    push_pair(16'd3, 16'd13);
    push_pair(16'd4, 16'd14);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_start", 32'(mul_start), 32'd0);
    check("arst_data", 32'(mul_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_jobs", 32'(jobs_done), 32'd0);
    check("arst_err", 32'(timeout_err), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Completion counter wrap from 0xFFFF.
    @(posedge clk);
    #2;
    force dut.jobs_done_q = 16'hFFFF;
    preload = 1'b1;
    @(posedge clk);
    #2;
    release dut.jobs_done_q;
    preload = 1'b0;
    @(negedge clk);
    check("wrap_preload", 32'(jobs_done), 32'hFFFF);
    fixed_delay = 1;
    emu_auto    = 1'b1;
    push_pair(16'd2, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (jobs_done != 16'hFFFF) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wrap_wait");
    check("wrap_jobs", 32'(jobs_done), 32'd0);

    // Randomized traffic with random multiplier latencies (some time out).
    do_reset();
    rand_delay = 1'b1;
    emu_auto   = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      in_a     = DATA_W'($urandom);
      in_b     = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && mq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("random_drain");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
